// File: rtl/dst_reg_pipe_if.sv
// Bus bundle for the destination-register tracking pipeline: decode-side
// candidates and controls in, per-stage tracking state and hazard flags out.
interface dst_reg_pipe_if #(
  parameter int AW    = 5,
  parameter int NSRC  = 4,
  parameter int SW    = 2,
  parameter int DEPTH = 3
);
  logic [NSRC*AW-1:0]  src;
  logic [SW-1:0]       sel;
  logic                in_valid;
  logic                in_wen;
  logic                stall;
  logic                flush;
  logic [AW-1:0]       rs_addr;
  logic [AW-1:0]       rt_addr;
  logic [DEPTH*AW-1:0] st_addr;
  logic [DEPTH-1:0]    st_wen;
  logic [DEPTH-1:0]    haz_rs;
  logic [DEPTH-1:0]    haz_rt;
  logic [AW-1:0]       wb_addr;
  logic                wb_wen;

  modport master (
    output src, sel, in_valid, in_wen, stall, flush, rs_addr, rt_addr,
    input  st_addr, st_wen, haz_rs, haz_rt, wb_addr, wb_wen
  );

  modport slave (
    input  src, sel, in_valid, in_wen, stall, flush, rs_addr, rt_addr,
    output st_addr, st_wen, haz_rs, haz_rt, wb_addr, wb_wen
  );
endinterface

// File: rtl/dst_reg_pipe.sv
// Destination-register select-and-track pipeline: picks the write register,
// carries it with its write-enable through DEPTH stages, and flags RAW matches.
module dst_reg_pipe #(
  parameter int AW          = 5,
  parameter int NSRC        = 4,
  parameter int SW          = 2,
  parameter int DEPTH       = 3,
  parameter int FLUSH_DEPTH = 1
) (
  input logic         clk,
  input logic         rst_n,
  dst_reg_pipe_if.slave bus
);

  logic [DEPTH-1:0][AW-1:0] addr_q, addr_d;
  logic [DEPTH-1:0]         wen_q, wen_d;
  logic [AW-1:0]            d;
  logic                     sel_ok;
  logic                     e;

  // An out-of-range or unknown select matches no candidate, leaving d = 0.
  always_comb begin
    d      = '0;
    sel_ok = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (bus.sel == SW'(i)) begin
        d      = bus.src[i*AW +: AW];
        sel_ok = 1'b1;
      end
    end
  end

  assign e = bus.in_valid && bus.in_wen && sel_ok && (d != '0);

  always_comb begin
    addr_d = addr_q;
    wen_d  = wen_q;
    if (!bus.stall) begin
      addr_d[0] = d;
      wen_d[0]  = e;
      for (int k = 1; k < DEPTH; k++) begin
        addr_d[k] = addr_q[k-1];
        wen_d[k]  = wen_q[k-1];
      end
      // The first unflushed stage would inherit a squashed entry, so it takes a bubble.
      for (int k = 0; k < DEPTH; k++) begin
        if (bus.flush && (k == FLUSH_DEPTH)) begin
          addr_d[k] = '0;
          wen_d[k]  = 1'b0;
        end
      end
    end
    for (int k = 0; k < DEPTH; k++) begin
      if (bus.flush && (k < FLUSH_DEPTH)) begin
        addr_d[k] = '0;
        wen_d[k]  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      wen_q  <= '0;
    end else begin
      addr_q <= addr_d;
      wen_q  <= wen_d;
    end
  end

  always_comb begin
    bus.haz_rs = '0;
    bus.haz_rt = '0;
    for (int k = 0; k < DEPTH; k++) begin
      bus.haz_rs[k] = wen_q[k] && (addr_q[k] == bus.rs_addr) && (bus.rs_addr != '0);
      bus.haz_rt[k] = wen_q[k] && (addr_q[k] == bus.rt_addr) && (bus.rt_addr != '0);
    end
  end

  assign bus.st_addr = addr_q;
  assign bus.st_wen  = wen_q;
  assign bus.wb_addr = addr_q[DEPTH-1];
  assign bus.wb_wen  = wen_q[DEPTH-1];

endmodule

// File: tb/tb_dst_reg_pipe.sv
// Directed bench for dst_reg_pipe: a vector table for single-cycle behaviour
// plus hand sequences for reset, stall, flush and the 3-candidate variant.
module tb_dst_reg_pipe;

  typedef struct {
    logic [3:0][4:0] src;
    logic [1:0]      sel;
    logic            valid;
    logic            wen;
    logic            stall;
    logic            flush;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      a0;
    logic [4:0]      a1;
    logic [4:0]      a2;
    logic [2:0]      ew;
    logic [2:0]      hrs;
    logic [2:0]      hrt;
  } vec_t;

  logic clk;
  logic rst_n;
  int   passCount;
  int   checkCount;

  dst_reg_pipe_if #(.AW(5), .NSRC(4), .SW(2), .DEPTH(3)) bus ();
  dst_reg_pipe_if #(.AW(5), .NSRC(3), .SW(2), .DEPTH(3)) bus3 ();

  dst_reg_pipe #(.AW(5), .NSRC(4), .SW(2), .DEPTH(3), .FLUSH_DEPTH(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  dst_reg_pipe #(.AW(5), .NSRC(3), .SW(2), .DEPTH(3), .FLUSH_DEPTH(1)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(int sel, int val, bit valid, bit wen, bit stall, bit flush,
                              int rs, int rt, int a0, int a1, int a2,
                              logic [2:0] ew, logic [2:0] hrs, logic [2:0] hrt);
    vec_t v;
    v.src      = '0;
    v.src[sel] = 5'(val);
    v.sel      = 2'(sel);
    v.valid    = valid;
    v.wen      = wen;
    v.stall    = stall;
    v.flush    = flush;
    v.rs       = 5'(rs);
    v.rt       = 5'(rt);
    v.a0       = 5'(a0);
    v.a1       = 5'(a1);
    v.a2       = 5'(a2);
    v.ew       = ew;
    v.hrs      = hrs;
    v.hrt      = hrt;
    return v;
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.src      = v.src;
    bus.sel      = v.sel;
    bus.in_valid = v.valid;
    bus.in_wen   = v.wen;
    bus.stall    = v.stall;
    bus.flush    = v.flush;
    bus.rs_addr  = v.rs;
    bus.rt_addr  = v.rt;
  endtask

  task automatic checkOutput(input string tag, input vec_t v);
    checkVal({tag, " st_addr"}, 32'(bus.st_addr), 32'({v.a2, v.a1, v.a0}));
    checkVal({tag, " st_wen"},  32'(bus.st_wen),  32'(v.ew));
    checkVal({tag, " haz_rs"},  32'(bus.haz_rs),  32'(v.hrs));
    checkVal({tag, " haz_rt"},  32'(bus.haz_rt),  32'(v.hrt));
    checkVal({tag, " wb_addr"}, 32'(bus.wb_addr), 32'(v.a2));
    checkVal({tag, " wb_wen"},  32'(bus.wb_wen),  32'(v.ew[2]));
  endtask

  task automatic enter(input int sel, input int val);
    applyStimulus(mk(sel, val, 1, 1, 0, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000));
  endtask

  task automatic idle();
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[12];

  initial begin
    passCount  = 0;
    checkCount = 0;
    vecs[0]  = mk(1, 12, 1, 1, 0, 0, 12, 0, 12,  0,  0, 3'b001, 3'b001, 3'b000);
    vecs[1]  = mk(0,  0, 0, 0, 0, 0, 12, 0,  0, 12,  0, 3'b010, 3'b010, 3'b000);
    vecs[2]  = mk(0,  0, 0, 0, 0, 0, 12, 0,  0,  0, 12, 3'b100, 3'b100, 3'b000);
    vecs[3]  = mk(0,  0, 0, 0, 0, 0, 12, 0,  0,  0,  0, 3'b000, 3'b000, 3'b000);
    vecs[4]  = mk(0,  0, 1, 1, 0, 0,  0, 0,  0,  0,  0, 3'b000, 3'b000, 3'b000);
    vecs[5]  = mk(2, 17, 1, 0, 0, 0, 17, 0, 17,  0,  0, 3'b000, 3'b000, 3'b000);
    vecs[6]  = mk(3,  8, 1, 1, 0, 0, 17, 8,  8, 17,  0, 3'b001, 3'b000, 3'b001);
    vecs[7]  = mk(1,  5, 1, 1, 0, 0,  5, 8,  5,  8, 17, 3'b011, 3'b001, 3'b010);
    vecs[8]  = mk(3,  8, 1, 1, 0, 0,  8, 3,  8,  5,  8, 3'b111, 3'b101, 3'b000);
    vecs[9]  = mk(1, 30, 1, 1, 1, 0,  5, 0,  8,  5,  8, 3'b111, 3'b010, 3'b000);
    vecs[10] = mk(1, 30, 1, 1, 0, 1,  5, 0,  0,  0,  5, 3'b100, 3'b100, 3'b000);
    vecs[11] = mk(0,  0, 0, 0, 0, 0,  0, 0,  0,  0,  0, 3'b000, 3'b000, 3'b000);

    idle();
    bus3.src = '0; bus3.sel = '0; bus3.in_valid = 1'b0; bus3.in_wen = 1'b0;
    bus3.stall = 1'b0; bus3.flush = 1'b0; bus3.rs_addr = '0; bus3.rt_addr = '0;
    rst_n = 1'b0;
    step();
    step();
    checkOutput("reset", vecs[11]);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i]);
      step();
      checkOutput($sformatf("vec%0d", i), vecs[i]);
    end

    // Stall: entry 7 holds in stage 0 across two stall cycles.
    enter(2, 7);
    step();
    checkVal("stall e1 st0", 32'(bus.st_addr[4:0]), 32'd7);
    applyStimulus(mk(1, 20, 1, 1, 1, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000));
    step();
    checkVal("stall e2 st0", 32'(bus.st_addr[4:0]), 32'd7);
    step();
    checkVal("stall e3 st0", 32'(bus.st_addr[4:0]), 32'd7);
    checkVal("stall e3 wen", 32'(bus.st_wen), 32'b001);
    idle();
    step();
    checkVal("stall e4 st1", 32'(bus.st_addr[9:5]), 32'd7);
    checkVal("stall e4 wb_wen", 32'(bus.wb_wen), 32'd0);
    step();
    checkVal("stall e5 wb_addr", 32'(bus.wb_addr), 32'd7);
    checkVal("stall e5 wb_wen", 32'(bus.wb_wen), 32'd1);
    step();
    checkVal("stall e6 wb_wen", 32'(bus.wb_wen), 32'd0);

    // Flush: 9 in stage1, 10 in stage0; flush+stall, then flush alone.
    enter(1, 9);
    step();
    enter(3, 10);
    step();
    checkVal("flush pre st", 32'(bus.st_addr[9:0]), 32'({5'd9, 5'd10}));
    applyStimulus(mk(2, 11, 1, 1, 1, 1, 9, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000));
    step();
    checkVal("flush+stall wen", 32'(bus.st_wen), 32'b010);
    checkVal("flush+stall st1", 32'(bus.st_addr[9:5]), 32'd9);
    checkVal("flush+stall haz_rs", 32'(bus.haz_rs), 32'b010);
    applyStimulus(mk(2, 11, 1, 1, 0, 1, 9, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000));
    step();
    checkVal("flush wen", 32'(bus.st_wen), 32'b100);
    checkVal("flush st", 32'(bus.st_addr), 32'({5'd9, 5'd0, 5'd0}));
    checkVal("flush haz_rs", 32'(bus.haz_rs), 32'b100);
    idle();
    step();
    step();

    // X select with no valid instruction must not create a tracked write.
    bus.sel = 2'bxx;
    bus.src = {5'd4, 5'd3, 5'd2, 5'd1};
    step();
    checkVal("xsel st_wen0", 32'(bus.st_wen[0]), 32'd0);
    idle();

    // Three-candidate variant: select 3 is out of range, select 2 is legal.
    bus3.src = {5'd21, 5'd22, 5'd23};
    bus3.sel = 2'd3; bus3.in_valid = 1'b1; bus3.in_wen = 1'b1;
    step();
    checkVal("nsrc3 sel3 wen", 32'(bus3.st_wen[0]), 32'd0);
    checkVal("nsrc3 sel3 addr", 32'(bus3.st_addr[4:0]), 32'd0);
    checkVal("nsrc3 haz_rs", 32'(bus3.haz_rs), 32'd0);
    bus3.sel = 2'd2;
    step();
    checkVal("nsrc3 sel2 wen", 32'(bus3.st_wen[0]), 32'd1);
    checkVal("nsrc3 sel2 addr", 32'(bus3.st_addr[4:0]), 32'd21);
    bus3.in_valid = 1'b0;

    // Asynchronous reset mid-stream, checked without any clock edge.
    enter(1, 4);
    step();
    enter(1, 5);
    step();
    enter(1, 6);
    bus.rs_addr = 5'd4;
    step();
    checkVal("prereset wb_wen", 32'(bus.wb_wen), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkVal("async rst st_addr", 32'(bus.st_addr), 32'd0);
    checkVal("async rst st_wen", 32'(bus.st_wen), 32'd0);
    checkVal("async rst haz_rs", 32'(bus.haz_rs), 32'd0);
    checkVal("async rst wb_wen", 32'(bus.wb_wen), 32'd0);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    step();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
